// File: rtl/bist_sequencer.sv
// Moore BIST sequencer: LFSR/scan/MISR schedule followed by a golden-signature compare.
// Optional BIST_DIAG_EN adds fail_sig/fail_valid diagnostic capture registers.
module bist_sequencer #(
    parameter int               CHAIN_LEN  = 8,
    parameter int               N_PATTERNS = 16,
    parameter int               SIG_W      = 3,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 3'b101
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             scan_en,
    output logic             running,
    output logic             bist_end,
`ifdef BIST_DIAG_EN
    output logic [SIG_W-1:0] fail_sig,
    output logic             fail_valid,
`endif
    output logic             pass_fail
);

    localparam int SHIFT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PAT_W   = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(N_PATTERNS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;
    localparam logic [2:0] ST_COMPARE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [SHIFT_W-1:0] shift_cnt;
    logic [PAT_W-1:0]   pat_cnt;
    logic               shift_last;
    logic               pat_last;

    assign shift_last = (shift_cnt == SHIFT_LAST);
    assign pat_last   = (pat_cnt == PAT_LAST);

    // DONE only exits on a low bist_start, so a held request never re-triggers a run.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bist_start) state_next = ST_INIT;
            ST_INIT:    state_next = ST_SHIFT;
            ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = pat_last ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:  if (shift_last) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE:    if (!bist_start) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // shift_cnt is shared by SHIFT and UNLOAD; both phases last CHAIN_LEN cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            pass_fail <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_INIT: begin
                    shift_cnt <= '0;
                    pat_cnt   <= '0;
                    pass_fail <= 1'b0;
                end
                ST_SHIFT, ST_UNLOAD: begin
                    shift_cnt <= shift_last ? '0 : shift_cnt + SHIFT_W'(1);
                end
                ST_CAPTURE: begin
                    pat_cnt <= pat_last ? '0 : pat_cnt + PAT_W'(1);
                end
                ST_COMPARE: begin
                    pass_fail <= (misr_sig == GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

`ifdef BIST_DIAG_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fail_sig   <= '0;
            fail_valid <= 1'b0;
        end else if (state == ST_INIT) begin
            fail_sig   <= '0;
            fail_valid <= 1'b0;
        end else if (state == ST_COMPARE) begin
            fail_sig   <= misr_sig;
            fail_valid <= (misr_sig != GOLDEN_SIG);
        end
    end
`endif

    // In CAPTURE the LFSR is held so its vector stays on the functional inputs.
    assign lfsr_load = (state == ST_INIT);
    assign misr_clr  = (state == ST_INIT);
    assign lfsr_en   = (state == ST_SHIFT);
    assign scan_en   = (state == ST_SHIFT) || (state == ST_UNLOAD);
    assign misr_en   = (state == ST_SHIFT) || (state == ST_CAPTURE) || (state == ST_UNLOAD);
    assign running   = (state != ST_IDLE) && (state != ST_DONE);
    assign bist_end  = (state == ST_DONE);

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: randomized runs checked against an arithmetic run model,
// plus directed reset, start-handling and CHAIN_LEN=1/N_PATTERNS=1 checks.
module tb_bist_sequencer;

    localparam int         C      = 8;
    localparam int         N      = 16;
    localparam logic [2:0] GOLDEN = 3'b101;
    localparam int         LAT    = 2 + N * (C + 1) + C;

    typedef struct {
        int         done_edge;
        bit         pass;
        logic [2:0] sig;
        int         n_scan;
        int         n_lfsr;
        int         n_misr;
        int         n_capture;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       bist_start = 1'b0;
    logic [2:0] misr_sig = 3'b000;
    logic       lfsr_load, lfsr_en, misr_clr, misr_en, scan_en, running, bist_end, pass_fail;

    logic       small_start = 1'b0;
    logic [2:0] small_sig = GOLDEN;
    logic       s_lfsr_load, s_lfsr_en, s_misr_clr, s_misr_en, s_scan_en, s_running, s_bist_end, s_pass_fail;

`ifdef BIST_DIAG_EN
    logic [2:0] fail_sig, s_fail_sig;
    logic       fail_valid, s_fail_valid;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   done_count = 0;
    int   c_load, c_clr, c_scan, c_lfsr, c_misr, c_cap;
    bit   prev_end;

    always #5 CLK = ~CLK;

    bist_sequencer #(.CHAIN_LEN(C), .N_PATTERNS(N), .SIG_W(3), .GOLDEN_SIG(GOLDEN)) dut (
        .CLK(CLK), .RST(RST), .bist_start(bist_start), .misr_sig(misr_sig),
        .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .misr_clr(misr_clr), .misr_en(misr_en),
        .scan_en(scan_en), .running(running), .bist_end(bist_end),
`ifdef BIST_DIAG_EN
        .fail_sig(fail_sig), .fail_valid(fail_valid),
`endif
        .pass_fail(pass_fail)
    );

    bist_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1), .SIG_W(3), .GOLDEN_SIG(GOLDEN)) dut_small (
        .CLK(CLK), .RST(RST), .bist_start(small_start), .misr_sig(small_sig),
        .lfsr_load(s_lfsr_load), .lfsr_en(s_lfsr_en), .misr_clr(s_misr_clr), .misr_en(s_misr_en),
        .scan_en(s_scan_en), .running(s_running), .bist_end(s_bist_end),
`ifdef BIST_DIAG_EN
        .fail_sig(s_fail_sig), .fail_valid(s_fail_valid),
`endif
        .pass_fail(s_pass_fail)
    );

    function automatic logic [7:0] outs();
        return {lfsr_load, lfsr_en, misr_clr, misr_en, scan_en, running, bist_end, pass_fail};
    endfunction

    function automatic logic [6:0] small_outs();
        return {s_lfsr_load, s_lfsr_en, s_misr_clr, s_misr_en, s_scan_en, s_running, s_bist_end};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: accumulates strobe activity and scores each completed run against the queue.
    always @(negedge CLK) begin
        if (!RST) begin
            c_load = 0; c_clr = 0; c_scan = 0; c_lfsr = 0; c_misr = 0; c_cap = 0;
            prev_end = 1'b0;
        end else begin
            c_load += int'(lfsr_load);
            c_clr  += int'(misr_clr);
            c_scan += int'(scan_en);
            c_lfsr += int'(lfsr_en);
            c_misr += int'(misr_en);
            c_cap  += int'(running && misr_en && !scan_en);
            if (bist_end && !prev_end) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("done_edge", edge_cnt, e.done_edge);
                    checkOutput("pass_fail", {31'd0, pass_fail}, {31'd0, e.pass});
                    checkOutput("running_at_done", {31'd0, running}, 32'd0);
                    checkOutput("lfsr_load_cnt", c_load, 32'd1);
                    checkOutput("misr_clr_cnt", c_clr, 32'd1);
                    checkOutput("scan_en_cnt", c_scan, e.n_scan);
                    checkOutput("lfsr_en_cnt", c_lfsr, e.n_lfsr);
                    checkOutput("misr_en_cnt", c_misr, e.n_misr);
                    checkOutput("capture_cnt", c_cap, e.n_capture);
`ifdef BIST_DIAG_EN
                    checkOutput("fail_sig", {29'd0, fail_sig}, {29'd0, e.sig});
                    checkOutput("fail_valid", {31'd0, fail_valid}, {31'd0, !e.pass});
`endif
                end
                c_load = 0; c_clr = 0; c_scan = 0; c_lfsr = 0; c_misr = 0; c_cap = 0;
                done_count++;
            end
            prev_end = bist_end;
        end
    end

    // Issues one run request and pushes the model's expected outcome for it.
    task automatic applyStimulus(input logic [2:0] sig, input bit hold);
        exp_t e;
        @(negedge CLK);
        misr_sig   = sig;
        bist_start = 1'b1;
        e.done_edge = edge_cnt + 1 + LAT;
        e.pass      = (sig == GOLDEN);
        e.sig       = sig;
        e.n_scan    = N * C + C;
        e.n_lfsr    = N * C;
        e.n_misr    = N * C + N + C;
        e.n_capture = N;
        exp_q.push_back(e);
        @(negedge CLK);
        if (!hold) bist_start = 1'b0;
    endtask

    task automatic waitDone(input int d0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LAT + 50 && !seen; i++) begin
            @(negedge CLK);
            #1;
            if (done_count > d0) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int         d0;
        logic [2:0] sig;
        logic [6:0] seq_exp [6];

        #3;
        checkOutput("reset_outputs", {24'd0, outs()}, 32'd0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1 checkOutput("idle_no_activity", {24'd0, outs()}, 32'd0);

        d0 = done_count;
        applyStimulus(GOLDEN, 1'b0);
        waitDone(d0);
        @(negedge CLK); #1;
        checkOutput("idle_after_pass_end", {31'd0, bist_end}, 32'd0);
        checkOutput("idle_pass_retained", {31'd0, pass_fail}, 32'd1);

        // Fail run with bist_start held across DONE.
        d0 = done_count;
        applyStimulus(3'b011, 1'b1);
        #1;
        checkOutput("init_lfsr_load", {31'd0, lfsr_load}, 32'd1);
        checkOutput("init_misr_clr", {31'd0, misr_clr}, 32'd1);
        @(negedge CLK); #1;
        checkOutput("init_clears_pass", {31'd0, pass_fail}, 32'd0);
        checkOutput("shift_scan_en", {31'd0, scan_en}, 32'd1);
        waitDone(d0);
        repeat (5) @(negedge CLK);
        #1;
        checkOutput("held_start_stays_done", {30'd0, bist_end, running}, 32'd2);
        bist_start = 1'b0;
        @(negedge CLK); #1;
        checkOutput("drop_start_idle", {31'd0, bist_end}, 32'd0);
        checkOutput("fail_retained", {31'd0, pass_fail}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge CLK);
            sig = ($urandom_range(0, 1) == 1) ? GOLDEN : 3'($urandom_range(0, 7));
            d0 = done_count;
            applyStimulus(sig, 1'b0);
            waitDone(d0);
            @(negedge CLK); #1;
            checkOutput("rand_idle_pass", {31'd0, pass_fail}, {31'd0, sig == GOLDEN});
        end

        d0 = done_count;
        applyStimulus(GOLDEN, 1'b0);
        waitDone(d0);

        // Abort mid-SHIFT: the run is not scoreboarded since it never completes.
        @(negedge CLK);
        bist_start = 1'b1;
        @(negedge CLK);
        bist_start = 1'b0;
        repeat (10) @(negedge CLK);
        #2 RST = 1'b0;
        #1 checkOutput("async_reset_outputs", {24'd0, outs()}, 32'd0);
        @(negedge CLK);
        #1 RST = 1'b1;
        repeat (4) @(negedge CLK);
        #1 checkOutput("post_reset_idle", {24'd0, outs()}, 32'd0);

        seq_exp[0] = 7'b1010010;
        seq_exp[1] = 7'b0101110;
        seq_exp[2] = 7'b0001010;
        seq_exp[3] = 7'b0001110;
        seq_exp[4] = 7'b0000010;
        seq_exp[5] = 7'b0000001;
        @(negedge CLK);
        small_start = 1'b1;
        @(negedge CLK);
        small_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 checkOutput($sformatf("small_seq_%0d", k), {25'd0, small_outs()}, {25'd0, seq_exp[k]});
            @(negedge CLK);
        end
        #1 checkOutput("small_pass_fail", {31'd0, s_pass_fail}, 32'd1);

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
Moore-type BIST sequencer for the scan-wrapped circuit12 test path. It drives the LFSR pattern source, the scan chain and the MISR compactor through a fixed pattern count, then compares the final MISR signature against a golden value. It replaces the level-only BIST control with a full shift/capture/unload/compare schedule and produces registered bist_end and pass_fail.

Parameters:
CHAIN_LEN, 8, scan chain length in flops (≥1)
N_PATTERNS, 16, number of shift+capture patterns (≥1)
SIG_W, 3, MISR signature width
GOLDEN_SIG, 3'b101, expected final signature (width SIG_W)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-low
bist_start  in  1  level request; sampled only in IDLE and DONE
misr_sig  in  SIG_W  current MISR signature {h2,h1,h0}
lfsr_load  out  1  load LFSR seed (INIT only)
lfsr_en  out  1  advance LFSR
misr_clr  out  1  clear MISR (INIT only)
misr_en  out  1  MISR compaction enable
scan_en  out  1  scan shift mode / test-vector mux select
running  out  1  high in every state except IDLE and DONE
bist_end  out  1  high in DONE
pass_fail  out  1  1 = signature matched; registered

Behaviour:
- Reset: RST=0 forces IDLE asynchronously. All counters are 0; all outputs are 0, including pass_fail.
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE. Outputs decode from the state register only (Moore). No combinational path exists from bist_start to any output.
- IDLE: all strobes 0. bist_start=1 -> INIT.
- INIT (1 cycle): lfsr_load=1, misr_clr=1. Clears shift_cnt and pat_cnt. Clears pass_fail. -> SHIFT.
- SHIFT: scan_en=1, lfsr_en=1, misr_en=1. shift_cnt increments each cycle. When shift_cnt==CHAIN_LEN-1: clear shift_cnt -> CAPTURE.
- CAPTURE (1 cycle): scan_en=0, lfsr_en=0 (LFSR vector held on functional inputs), misr_en=1. pat_cnt increments.
  - If pat_cnt==N_PATTERNS-1 -> UNLOAD.
  - Otherwise -> SHIFT.
- UNLOAD: scan_en=1, misr_en=1, lfsr_en=0 for CHAIN_LEN cycles, flushing the last capture. -> COMPARE.
- COMPARE (1 cycle): pass_fail <= (misr_sig==GOLDEN_SIG). -> DONE.
- DONE: bist_end=1, pass_fail held. bist_start=0 -> IDLE. pass_fail keeps its value in IDLE until the next INIT.
- Latency: DONE is entered 2 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN edges after the edge that samples bist_start=1 in IDLE. With defaults this is 154 edges.
- bist_start deasserted mid-run: ignored; the sequence completes.
- bist_start held high through DONE: the block stays in DONE. It never auto-restarts, so a new run needs a 0 then 1 on bist_start.
- Counter widths: $clog2 of their limits, minimum 1 bit. Compares use equality only; no counter wraps.
- Reset asserted mid-run: immediate return to IDLE; pass_fail=0, bist_end=0.
- Boundary cases:
  - CHAIN_LEN=1: SHIFT and UNLOAD each last exactly 1 cycle.
  - N_PATTERNS=1: the first CAPTURE goes straight to UNLOAD.

Optional Feature:
Macro: BIST_DIAG_EN
- Defined: adds output fail_sig [SIG_W-1:0] and output fail_valid (1 bit).
  - In COMPARE: fail_sig <= misr_sig, and fail_valid <= (misr_sig!=GOLDEN_SIG).
  - Both hold until the next INIT clears them. Both reset to 0.
- Undefined: neither port nor register exists; all other behaviour is identical.

Test Plan:
- Reset: RST=0 while in SHIFT -> same cycle all outputs 0 and state IDLE; after RST=1, no activity until bist_start=1.
- Pass run (defaults): bist_start=1 for 1 cycle, misr_sig driven 3'b101 in COMPARE -> bist_end=1 at edge 154, pass_fail=1, running=0, exactly 16 CAPTURE cycles seen.
- Fail run: misr_sig=3'b011 at COMPARE -> pass_fail=0, bist_end=1; with BIST_DIAG_EN, fail_sig=3'b011 and fail_valid=1.
- Strobe counts: over a default run, count strobe-high cycles -> lfsr_load=1, misr_clr=1, scan_en=136 (16*8+8), lfsr_en=128, misr_en=152.
- Start handling: bist_start held high across DONE -> stays in DONE with bist_end=1; drop to 0 -> IDLE next edge with pass_fail retained; pulse again -> INIT clears pass_fail.
- Small parameters: CHAIN_LEN=1, N_PATTERNS=1 -> state sequence INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; bist_end at edge 5.
